// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86-64 decode slice.
//   - instruction codes (icode), status codes, stack-pointer register index
//   - default datapath / register-file geometry
//   - bubble (nop) contents for the E pipeline register
package y86_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int NREG_DEF   = 16;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    // %rsp register index
    localparam int RSP = 4;

    // Bubble contents of the E register (values are zero, registers are "none")
    localparam logic [3:0] BUBBLE_STAT  = STAT_AOK;
    localparam logic [3:0] BUBBLE_ICODE = I_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

    // Instructions whose result comes from memory (load-use producers)
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: NREG x DATA_W register file for the decode stage.
//   clk, rst          : clock, synchronous active-high reset (clears every entry)
//   we_addr_i/data_i  : E-result write port
//   wm_addr_i/data_i  : memory-result write port; wins over E port on same index
//   ra_addr_i/ra_data_o, rb_addr_i/rb_data_o : combinational read ports
//   dbg_addr_i/dbg_data_o : combinational debug read port
// Index RNONE is never written and always reads as zero.
module pipe_regfile #(
    parameter int DATA_W = 64,
    parameter int NREG   = 16,
    parameter int RNONE  = NREG - 1,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RW-1:0]     we_addr_i,
    input  logic [DATA_W-1:0] we_data_i,
    input  logic [RW-1:0]     wm_addr_i,
    input  logic [DATA_W-1:0] wm_data_i,
    input  logic [RW-1:0]     ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [RW-1:0]     rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [RW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam logic [RW-1:0] RNONE_R = RW'(RNONE);

    logic [DATA_W-1:0] regs_q [NREG];

    function automatic logic writable(input logic [RW-1:0] a);
        return (a != RNONE_R) && (int'(a) < NREG);
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [RW-1:0] a);
        if ((a == RNONE_R) || (int'(a) >= NREG))
            return '0;
        return regs_q[a];
    endfunction

    // The M port is written after the E port so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            if (writable(we_addr_i))
                regs_q[we_addr_i] <= we_data_i;
            if (writable(wm_addr_i))
                regs_q[wm_addr_i] <= wm_data_i;
        end
    end

    assign ra_data_o  = rd(ra_addr_i);
    assign rb_data_o  = rd(rb_addr_i);
    assign dbg_data_o = rd(dbg_addr_i);

endmodule

// File: rtl/pipe_decode.sv
// pipe_decode: Y86-64 decode stage with register file, forwarding,
// load-use detection and the E pipeline register.
//   clk, rst                    : clock, synchronous active-high reset
//   D_*                         : instruction in the D register
//   e_/M_/W_ dst*/val*          : forwarding sources (W pair also writes the file)
//   E_icode_in, E_dstM_in       : instruction now in E, for load-use detection
//   E_bubble_ext, E_stall       : E register control (stall beats bubble)
//   dbg_addr/dbg_data           : raw register-file read, no forwarding
//   load_use                    : combinational hazard flag
//   E_*                         : registered E-stage fields
module pipe_decode
    import y86_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int RNONE  = NREG - 1,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [RW-1:0]     D_rA,
    input  logic [RW-1:0]     D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [RW-1:0]     e_dstE,
    input  logic [RW-1:0]     M_dstE,
    input  logic [RW-1:0]     M_dstM,
    input  logic [RW-1:0]     W_dstE,
    input  logic [RW-1:0]     W_dstM,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        E_icode_in,
    input  logic [RW-1:0]     E_dstM_in,
    input  logic              E_bubble_ext,
    input  logic              E_stall,
    input  logic [RW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              load_use,
    output logic [3:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [RW-1:0]     E_dstE,
    output logic [RW-1:0]     E_dstM,
    output logic [RW-1:0]     E_srcA,
    output logic [RW-1:0]     E_srcB
);

    localparam logic [RW-1:0] RNONE_R = RW'(RNONE);
    localparam logic [RW-1:0] RSP_R   = RW'(RSP);

    // ---------------- register specifier decode ----------------
    logic [RW-1:0] srcA, srcB, dstE, dstM;

    always_comb begin
        srcA = RNONE_R;
        srcB = RNONE_R;
        dstE = RNONE_R;
        dstM = RNONE_R;
        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ: srcA = D_rA;
            I_RET, I_PUSHQ, I_POPQ:    srcA = RSP_R;
            default: ;
        endcase
        case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:        srcB = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:   srcB = RSP_R;
            default: ;
        endcase
        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:        dstE = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:   dstE = RSP_R;
            default: ;
        endcase
        case (D_icode)
            I_MRMOVQ, I_POPQ: dstM = D_rA;
            default: ;
        endcase
    end

    // ---------------- register file ----------------
    logic [DATA_W-1:0] rf_a, rf_b;

    pipe_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RNONE  (RNONE)
    ) u_rf (
        .clk        (clk),
        .rst        (rst),
        .we_addr_i  (W_dstE),
        .we_data_i  (W_valE),
        .wm_addr_i  (W_dstM),
        .wm_data_i  (W_valM),
        .ra_addr_i  (srcA),
        .ra_data_o  (rf_a),
        .rb_addr_i  (srcB),
        .rb_data_o  (rf_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // ---------------- forwarding ----------------
    // Youngest producer wins; W_dstM beats W_dstE so the forwarded value
    // matches what the file will hold after the write.
    function automatic logic [DATA_W-1:0] fwd(input logic [RW-1:0]     src,
                                              input logic [DATA_W-1:0] rf_val);
        if (src == RNONE_R)     return '0;
        if (src == e_dstE)      return e_valE;
        if (src == M_dstM)      return m_valM;
        if (src == M_dstE)      return M_valE;
        if (src == W_dstM)      return W_valM;
        if (src == W_dstE)      return W_valE;
        return rf_val;
    endfunction

    logic [DATA_W-1:0] valA, valB;

    always_comb begin
        valB = fwd(srcB, rf_b);
        // jXX and call carry the fall-through PC down the pipe in valA
        if (D_icode == I_JXX || D_icode == I_CALL)
            valA = D_valP;
        else
            valA = fwd(srcA, rf_a);
    end

    // ---------------- load-use hazard ----------------
    assign load_use = is_load(E_icode_in) && (E_dstM_in != RNONE_R) &&
                      ((E_dstM_in == srcA) || (E_dstM_in == srcB));

    // ---------------- E pipeline register ----------------
    logic [3:0]        stat_q,  stat_d,  icode_q, icode_d, ifun_q, ifun_d;
    logic [DATA_W-1:0] valC_q,  valC_d,  valA_q,  valA_d,  valB_q, valB_d;
    logic [RW-1:0]     dstE_q,  dstE_d,  dstM_q,  dstM_d;
    logic [RW-1:0]     srcA_q,  srcA_d,  srcB_q,  srcB_d;

    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        valC_d  = valC_q;
        valA_d  = valA_q;
        valB_d  = valB_q;
        dstE_d  = dstE_q;
        dstM_d  = dstM_q;
        srcA_d  = srcA_q;
        srcB_d  = srcB_q;
        if (E_stall) begin
            // hold: defaults already keep the current contents
        end else if (E_bubble_ext || load_use) begin
            stat_d  = BUBBLE_STAT;
            icode_d = BUBBLE_ICODE;
            ifun_d  = BUBBLE_IFUN;
            valC_d  = '0;
            valA_d  = '0;
            valB_d  = '0;
            dstE_d  = RNONE_R;
            dstM_d  = RNONE_R;
            srcA_d  = RNONE_R;
            srcB_d  = RNONE_R;
        end else begin
            stat_d  = D_stat;
            icode_d = D_icode;
            ifun_d  = D_ifun;
            valC_d  = D_valC;
            valA_d  = valA;
            valB_d  = valB;
            dstE_d  = dstE;
            dstM_d  = dstM;
            srcA_d  = srcA;
            srcB_d  = srcB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q  <= BUBBLE_STAT;
            icode_q <= BUBBLE_ICODE;
            ifun_q  <= BUBBLE_IFUN;
            valC_q  <= '0;
            valA_q  <= '0;
            valB_q  <= '0;
            dstE_q  <= RNONE_R;
            dstM_q  <= RNONE_R;
            srcA_q  <= RNONE_R;
            srcB_q  <= RNONE_R;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            valC_q  <= valC_d;
            valA_q  <= valA_d;
            valB_q  <= valB_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
            srcA_q  <= srcA_d;
            srcB_q  <= srcB_d;
        end
    end

    assign E_stat  = stat_q;
    assign E_icode = icode_q;
    assign E_ifun  = ifun_q;
    assign E_valC  = valC_q;
    assign E_valA  = valA_q;
    assign E_valB  = valB_q;
    assign E_dstE  = dstE_q;
    assign E_dstM  = dstM_q;
    assign E_srcA  = srcA_q;
    assign E_srcB  = srcB_q;

endmodule

// File: tb/tb_pipe_decode.sv
module tb_pipe_decode;

    localparam int NONE = 15;

    logic        clk, rst;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  E_icode_in, E_dstM_in;
    logic        E_bubble_ext, E_stall;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic        load_use;
    logic [3:0]  E_stat, E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_decode dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM),
        .W_valE(W_valE), .W_valM(W_valM),
        .E_icode_in(E_icode_in), .E_dstM_in(E_dstM_in),
        .E_bubble_ext(E_bubble_ext), .E_stall(E_stall),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .load_use(load_use),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; D_stat = 1; D_icode = 1; D_ifun = 0; D_rA = NONE; D_rB = NONE;
        D_valC = 0; D_valP = 0;
        e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
        E_icode_in = 1; E_dstM_in = NONE; E_bubble_ext = 0; E_stall = 0; dbg_addr = 0;
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } e_t;

    logic [63:0] rf_m [16];
    e_t          em;

    function automatic e_t bubble();
        e_t b;
        b.stat = 1; b.icode = 1; b.ifun = 0; b.valC = 0; b.valA = 0; b.valB = 0;
        b.dstE = NONE; b.dstM = NONE; b.srcA = NONE; b.srcB = NONE;
        return b;
    endfunction

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6}) return ra;
        if (ic inside {4'h9, 4'hA, 4'hB}) return 4;
        return NONE;
    endfunction
    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4;
        return NONE;
    endfunction
    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4;
        return NONE;
    endfunction
    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'(NONE);
    endfunction

    // Ordered list of in-flight producers, youngest first, then the file.
    function automatic logic [63:0] m_read(input logic [3:0] r);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        if (r == NONE) return 0;
        d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        foreach (d[k]) if (d[k] == r) return v[k];
        return rf_m[r];
    endfunction

    function automatic logic m_load_use();
        logic [3:0] a, b;
        a = m_srcA(D_icode, D_rA);
        b = m_srcB(D_icode, D_rB);
        return (E_icode_in == 5 || E_icode_in == 11) && E_dstM_in != NONE &&
               (E_dstM_in == a || E_dstM_in == b);
    endfunction

    function automatic e_t m_decode();
        e_t x;
        x.stat = D_stat; x.icode = D_icode; x.ifun = D_ifun; x.valC = D_valC;
        x.srcA = m_srcA(D_icode, D_rA); x.srcB = m_srcB(D_icode, D_rB);
        x.dstE = m_dstE(D_icode, D_rB); x.dstM = m_dstM(D_icode, D_rA);
        x.valA = (D_icode == 7 || D_icode == 8) ? D_valP : m_read(x.srcA);
        x.valB = m_read(x.srcB);
        return x;
    endfunction

    task automatic chk_e(input string tag, input e_t x);
        chk({tag, ".stat"},  E_stat,  x.stat);
        chk({tag, ".icode"}, E_icode, x.icode);
        chk({tag, ".ifun"},  E_ifun,  x.ifun);
        chk({tag, ".valC"},  E_valC,  x.valC);
        chk({tag, ".valA"},  E_valA,  x.valA);
        chk({tag, ".valB"},  E_valB,  x.valB);
        chk({tag, ".dstE"},  E_dstE,  x.dstE);
        chk({tag, ".dstM"},  E_dstM,  x.dstM);
        chk({tag, ".srcA"},  E_srcA,  x.srcA);
        chk({tag, ".srcB"},  E_srcB,  x.srcB);
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [3:0] rdst();
        return ($urandom_range(0, 2) == 0) ? 4'(NONE) : 4'($urandom_range(0, 7));
    endfunction

    // ---------------- decode table ----------------
    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  srcA, srcB, dstE, dstM;
        logic [63:0] valA;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{4'h0, NONE, NONE, NONE, NONE, 64'h0};
        tbl[1]  = '{4'h1, NONE, NONE, NONE, NONE, 64'h0};
        tbl[2]  = '{4'h2, 7,    NONE, 9,    NONE, 64'h0};
        tbl[3]  = '{4'h3, NONE, NONE, 9,    NONE, 64'h0};
        tbl[4]  = '{4'h4, 7,    9,    NONE, NONE, 64'h0};
        tbl[5]  = '{4'h5, NONE, 9,    NONE, 7,    64'h0};
        tbl[6]  = '{4'h6, 7,    9,    9,    NONE, 64'h0};
        tbl[7]  = '{4'h7, NONE, NONE, NONE, NONE, 64'h1234};
        tbl[8]  = '{4'h8, NONE, 4,    4,    NONE, 64'h1234};
        tbl[9]  = '{4'h9, 4,    4,    4,    NONE, 64'h0};
        tbl[10] = '{4'hA, 4,    4,    4,    NONE, 64'h0};
        tbl[11] = '{4'hB, 4,    4,    4,    7,    64'h0};
        tbl[12] = '{4'hC, NONE, NONE, NONE, NONE, 64'h0};
        tbl[13] = '{4'hF, NONE, NONE, NONE, NONE, 64'h0};

        idle();
        // reset state
        rst = 1;
        step();
        rst = 0;
        chk("rst.E_icode", E_icode, 1);
        chk("rst.E_dstE",  E_dstE,  NONE);
        chk("rst.E_stat",  E_stat,  1);
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1;
            chk($sformatf("rst.reg%0d", a), dbg_data, 0);
        end

        // decode table against a zeroed file and no forwarding
        for (int i = 0; i < 14; i++) begin
            D_icode = tbl[i].icode; D_rA = 7; D_rB = 9; D_valP = 64'h1234;
            step();
            chk($sformatf("tbl%0d.icode", i), E_icode, tbl[i].icode);
            chk($sformatf("tbl%0d.srcA", i),  E_srcA,  tbl[i].srcA);
            chk($sformatf("tbl%0d.srcB", i),  E_srcB,  tbl[i].srcB);
            chk($sformatf("tbl%0d.dstE", i),  E_dstE,  tbl[i].dstE);
            chk($sformatf("tbl%0d.dstM", i),  E_dstM,  tbl[i].dstM);
            chk($sformatf("tbl%0d.valA", i),  E_valA,  tbl[i].valA);
        end
        idle();

        // write then read through the file
        W_dstE = 3; W_valE = 64'h55;
        step();
        W_dstE = NONE; D_icode = 6; D_rA = 3; D_rB = 3;
        step();
        chk("wr.valA", E_valA, 64'h55);
        chk("wr.valB", E_valB, 64'h55);
        chk("wr.dstE", E_dstE, 3);
        idle();

        // forwarding priority
        D_icode = 2; D_rA = 2;
        e_dstE = 2; e_valE = 64'h11; M_dstM = 2; m_valM = 64'h22; W_dstE = 2; W_valE = 64'h33;
        step();
        chk("fwd.e", E_valA, 64'h11);
        e_dstE = NONE;
        step();
        chk("fwd.M", E_valA, 64'h22);
        M_dstM = NONE; W_dstE = NONE;
        step();
        chk("fwd.rf", E_valA, 64'h33);
        idle();

        // load-use bubble
        E_icode_in = 5; E_dstM_in = 1; D_icode = 6; D_rA = 1; D_rB = 2;
        #1;
        chk("lu.flag", load_use, 1);
        step();
        chk("lu.bubble.icode", E_icode, 1);
        chk("lu.bubble.srcA",  E_srcA,  NONE);
        // stall takes precedence over the hazard bubble
        E_icode_in = 1;
        step();
        chk("lu.load.icode", E_icode, 6);
        E_icode_in = 11; E_dstM_in = 2; E_stall = 1; D_icode = 3;  D_rB = 2;
        D_icode = 6;
        step();
        chk("stall.icode", E_icode, 6);
        chk("stall.srcA",  E_srcA,  1);
        chk("stall.srcB",  E_srcB,  2);
        idle();
        // external bubble
        D_icode = 6; D_rA = 1; D_rB = 2; E_bubble_ext = 1;
        step();
        chk("bub.icode", E_icode, 1);
        idle();

        // dual write to the same index: memory value wins; RNONE stays zero
        W_dstE = 4; W_dstM = 4; W_valE = 64'hA; W_valM = 64'hB;
        step();
        idle();
        dbg_addr = 4;
        #1;
        chk("dual.reg4", dbg_data, 64'hB);
        W_dstE = NONE; W_valE = 64'hFF;
        step();
        dbg_addr = NONE;
        #1;
        chk("rnone.read", dbg_data, 0);
        idle();

        // call: valA is valP, valB is %rsp
        W_dstE = 4; W_valE = 64'h200;
        step();
        W_dstE = NONE; D_icode = 8; D_valP = 64'h100;
        step();
        chk("call.valA", E_valA, 64'h100);
        chk("call.valB", E_valB, 64'h200);
        chk("call.dstE", E_dstE, 4);
        idle();

        // reset overrides a same-edge write
        rst = 1; W_dstE = 5; W_valE = 64'h77; D_icode = 6;
        step();
        idle();
        dbg_addr = 5;
        #1;
        chk("rstw.reg5", dbg_data, 0);
        chk("rstw.icode", E_icode, 1);

        // randomized run against the reference
        for (int n = 0; n < 400; n++) begin
            logic lu;
            e_t   nx;
            rst = (n == 0) || ($urandom_range(0, 39) == 0);
            D_stat = 4'($urandom_range(1, 4)); D_icode = 4'($urandom);
            D_ifun = 4'($urandom); D_rA = 4'($urandom_range(0, 7)); D_rB = 4'($urandom_range(0, 7));
            D_valC = r64(); D_valP = r64();
            e_dstE = rdst(); M_dstE = rdst(); M_dstM = rdst(); W_dstE = rdst(); W_dstM = rdst();
            e_valE = r64(); M_valE = r64(); m_valM = r64(); W_valE = r64(); W_valM = r64();
            E_icode_in = ($urandom_range(0, 1) == 0) ? 4'(5 + 6 * $urandom_range(0, 1)) : 4'($urandom);
            E_dstM_in = rdst();
            E_bubble_ext = ($urandom_range(0, 9) == 0);
            E_stall = ($urandom_range(0, 7) == 0);
            dbg_addr = 4'($urandom);
            #1;
            lu = m_load_use();
            chk($sformatf("rnd%0d.load_use", n), load_use, lu);
            if (rst) begin
                nx = bubble();
                foreach (rf_m[k]) rf_m[k] = 0;
            end else begin
                if (E_stall)                nx = em;
                else if (E_bubble_ext || lu) nx = bubble();
                else                        nx = m_decode();
                if (W_dstE != NONE) rf_m[W_dstE] = W_valE;
                if (W_dstM != NONE) rf_m[W_dstM] = W_valM;
            end
            em = nx;
            step();
            chk_e($sformatf("rnd%0d", n), em);
            chk($sformatf("rnd%0d.dbg", n), dbg_data, (dbg_addr == NONE) ? 64'h0 : rf_m[dbg_addr]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
